// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store requesters onto one Avalon master port.
// It runs one non-pipelined transaction at a time and returns a registered done pulse.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteen,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        bus_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   input  logic        waitrequest
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 1: data requester owns the bus
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic        read_q, read_d, write_q, write_d;
   logic [3:0]  be_q, be_d;
   logic        if_done_q, if_done_d, d_done_q, d_done_d, err_q, err_d;
   logic        timeout_hit;

   // Abort fires on the edge that completes the TIMEOUT-th stalled cycle.
   assign timeout_hit = (TIMEOUT != 0) && waitrequest && (({1'b0, cnt_q} + 17'd1) >= TO_LIM);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      read_d     = read_q;
      write_d    = write_q;
      be_d       = be_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_done_d  = 1'b0;
      d_done_d   = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Data first: it belongs to the older instruction in flight.
            if (d_read || d_write) begin
               addr_d  = d_addr;
               read_d  = d_read;
               write_d = ~d_read & d_write;
               be_d    = d_byteen;
               owner_d = 1'b1;
               if (!d_read) wdata_d = d_wdata;
               state_d = BUS;
            end else if (if_req) begin
               addr_d  = if_addr & 32'hFFFF_FFFC;
               read_d  = 1'b1;
               write_d = 1'b0;
               be_d    = 4'hF;
               owner_d = 1'b0;
               state_d = BUS;
            end
         end
         BUS: begin
            if (waitrequest) cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (!waitrequest || timeout_hit) begin
               if (!waitrequest && read_q) begin
                  if (owner_q) d_rdata_d  = readdata;
                  else         if_rdata_d = readdata;
               end
               read_d    = 1'b0;
               write_d   = 1'b0;
               if_done_d = ~owner_q;
               d_done_d  = owner_q;
               err_d     = waitrequest;
               state_d   = RESP;
            end
         end
         RESP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         be_q       <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_done_q  <= 1'b0;
         d_done_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         read_q     <= read_d;
         write_q    <= write_d;
         be_q       <= be_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_done_q  <= if_done_d;
         d_done_q   <= d_done_d;
         err_q      <= err_d;
      end
   end

   assign address    = addr_q;
   assign read       = read_q;
   assign write      = write_q;
   assign writedata  = wdata_q;
   assign byteenable = be_q;
   assign if_rdata   = if_rdata_q;
   assign d_rdata    = d_rdata_q;
   assign if_done    = if_done_q;
   assign d_done     = d_done_q;
   assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter.
// Expectations come from a transaction-level model: who wins, how long it takes, and what it returns.
module tb_mem_bus_arbiter;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0, reset = 1'b1;
   logic        if_req = 1'b0, d_read = 1'b0, d_write = 1'b0, waitrequest = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, readdata = '0;
   logic [3:0]  d_byteen = '0;
   logic [31:0] if_rdata, d_rdata, address, writedata;
   logic        if_done, d_done, bus_err, read, write;
   logic [3:0]  byteenable;

   int          n_cmp = 0, n_err = 0;
   logic [31:0] m_if_rdata = '0, m_d_rdata = '0, m_wdata = '0;

   mem_bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byteen(d_byteen), .d_rdata(d_rdata), .d_done(d_done), .bus_err(bus_err),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One access from IDLE: k stalled cycles, rdv presented on the completing edge.
   task automatic do_access(input bit fr, input bit dr, input bit dw,
                            input logic [31:0] fa, input logic [31:0] da,
                            input logic [31:0] dwd, input logic [3:0] dbe,
                            input logic [31:0] rdv, input int k, input bit hold);
      bit          data, er, ew, abort;
      logic [31:0] ea;
      logic [3:0]  ebe;
      int          nb;
      data = dr | dw;
      if_req = fr; if_addr = fa; d_read = dr; d_write = dw;
      d_addr = da; d_wdata = dwd; d_byteen = dbe;
      waitrequest = 1'($urandom); readdata = $urandom;
      ea    = data ? da : {fa[31:2], 2'b00};
      er    = data ? dr : 1'b1;
      ew    = data && !dr && dw;
      ebe   = data ? dbe : 4'hF;
      if (ew) m_wdata = dwd;
      abort = (TO != 0) && (k >= int'(TO));
      nb    = abort ? int'(TO) : k + 1;
      tick;
      for (int c = 1; c <= nb; c++) begin
         n_cmp++;
         if (address !== ea || read !== er || write !== ew || writedata !== m_wdata ||
             byteenable !== ebe || if_done !== 1'b0 || d_done !== 1'b0) begin
            n_err++;
            $display("FAIL bus_hold cyc%0d: addr=%h rd=%b wr=%b wd=%h be=%h ifd=%b dd=%b, want addr=%h rd=%b wr=%b wd=%h be=%h done=0",
                     c, address, read, write, writedata, byteenable, if_done, d_done,
                     ea, er, ew, m_wdata, ebe);
         end
         waitrequest = (c <= k);
         readdata    = (c == nb) ? rdv : $urandom;
         tick;
      end
      if (!abort && er) begin
         if (data) m_d_rdata = rdv;
         else      m_if_rdata = rdv;
      end
      n_cmp++;
      if (read !== 1'b0 || write !== 1'b0 || if_done !== !data || d_done !== data ||
          bus_err !== abort || if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin
         n_err++;
         $display("FAIL resp: rd=%b wr=%b ifd=%b dd=%b err=%b ifr=%h dr=%h, want rd=0 wr=0 ifd=%b dd=%b err=%b ifr=%h dr=%h",
                  read, write, if_done, d_done, bus_err, if_rdata, d_rdata,
                  !data, data, abort, m_if_rdata, m_d_rdata);
      end
      if (!hold) begin
         if_req = fr && data;
         d_read = 1'b0;
         d_write = 1'b0;
      end
      waitrequest = 1'($urandom);
      tick;
      n_cmp++;
      if (read !== 1'b0 || write !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 || bus_err !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after: rd=%b wr=%b ifd=%b dd=%b err=%b, want all 0",
                  read, write, if_done, d_done, bus_err);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #12;
      n_cmp++;
      if (address !== '0 || read !== 1'b0 || write !== 1'b0 || writedata !== '0 ||
          byteenable !== '0 || if_done !== 1'b0 || d_done !== 1'b0 || bus_err !== 1'b0 ||
          if_rdata !== '0 || d_rdata !== '0) begin
         n_err++;
         $display("FAIL reset_values: addr=%h rd=%b wr=%b wd=%h be=%h ifd=%b dd=%b err=%b ifr=%h dr=%h, want all 0",
                  address, read, write, writedata, byteenable, if_done, d_done, bus_err, if_rdata, d_rdata);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_fetch;
      do_access(1, 0, 0, 32'hBFC0_0002, '0, '0, '0, 32'h2402_0005, 0, 0);
   endtask

   task automatic test_store_stall;
      do_access(0, 0, 1, '0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011, $urandom, 3, 0);
   endtask

   task automatic test_simultaneous;
      do_access(1, 1, 0, 32'h0000_0100, 32'h0000_2000, '0, 4'hF, 32'h1111_2222, 0, 0);
      do_access(1, 0, 0, 32'h0000_0100, '0, '0, '0, 32'h3333_4444, 0, 0);
   endtask

   task automatic test_timeout;
      do_access(1, 0, 0, 32'h0000_0200, '0, '0, '0, 32'hCAFE_F00D, 7, 0);
   endtask

   task automatic test_reset_mid;
      if_req = 1'b1; if_addr = 32'h0000_0300; waitrequest = 1'b1;
      tick;
      #3;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (read !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 || address !== '0) begin
         n_err++;
         $display("FAIL reset_mid: rd=%b ifd=%b dd=%b addr=%h, want 0", read, if_done, d_done, address);
      end
      if_req = 1'b0;
      m_if_rdata = '0; m_d_rdata = '0; m_wdata = '0;
      tick;
      @(negedge clk);
      reset = 1'b0;
      do_access(1, 0, 0, 32'h0000_0404, '0, '0, '0, 32'h5555_AAAA, 0, 0);
   endtask

   task automatic test_lagging;
      do_access(0, 1, 0, '0, 32'h0000_0500, '0, 4'hF, 32'h7777_8888, 1, 1);
      do_access(1, 0, 0, 32'h0000_0600, '0, '0, '0, 32'h9999_0000, 0, 1);
      do_access(0, 0, 1, '0, 32'h0000_0700, 32'h0BAD_F00D, 4'b1100, '0, 2, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 30; i++) begin
         int          p, k;
         bit          fr, dr, dw;
         logic [31:0] fa;
         p  = $urandom_range(0, 4);
         k  = $urandom_range(0, 5);
         fr = (p == 0) || (p == 3);
         dr = (p == 1) || (p == 3) || (p == 4);
         dw = (p == 2) || (p == 4);
         fa = $urandom;
         do_access(fr, dr, dw, fa, $urandom, $urandom, 4'($urandom), $urandom, k,
                   1'($urandom_range(0, 1)));
         if (p == 3)
            do_access(1, 0, 0, fa, '0, '0, '0, $urandom, $urandom_range(0, 5), 0);
      end
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_store_stall;
      test_simultaneous;
      test_timeout;
      test_reset_mid;
      test_lagging;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
